sift_kp_collector: RTL
======================

Name: sift_kp_collector

Overview:
- Sits directly downstream of the SIFT feature top (DoG + local-extreme stage).
- Consumes the per-pixel keypoint strobe stream and tags each keypoint with raster coordinates and octave.
- Buffers keypoints in a small FIFO and presents them on a valid/ready stream to the descriptor/orientation stage or the host readout.
- Tracks octave 0 (full image) and octave 1 (downsampled) using the completion strobes.

Parameters:
- IMG_W, 512, octave-0 row length in samples (octave 1 uses IMG_W/2).
- IMG_H, 512, octave-0 row count (octave 1 uses IMG_H/2).
- COORD_W, 9, coordinate width; must satisfy 2^COORD_W >= IMG_W and >= IMG_H.
- FIFO_DEPTH, 16, keypoint buffer depth; power of two, >= 2.
- CONTRAST_TH, 8, minimum (max - min) spread; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- kp_en  in  1  one sample of the local-extreme stream is valid this cycle (one per raster position).
- kp_flag  in  1  current sample is a keypoint.
- kp_max  in  8  signed window maximum.
- kp_min  in  8  signed window minimum.
- complete1  in  1  octave-0 processing finished (level or pulse; rising edge used).
- complete2  in  1  octave-1 processing finished (rising edge used).
- frame_start  in  1  single-cycle pulse: rearm for a new image.
- m_valid  out  1  output keypoint valid.
- m_ready  in  1  downstream accepts.
- m_x  out  COORD_W  column.
- m_y  out  COORD_W  row.
- m_oct  out  1  0 = original image, 1 = downsampled.
- m_max  out  8  signed max.
- m_min  out  8  signed min.
- drop_cnt  out  8  saturating count of keypoints lost to FIFO full.
- frame_done  out  1  high in DONE state with FIFO empty.

Behaviour:
- Reset values: all outputs 0, FSM = OCT0, x = y = 0, FIFO empty.
- FSM has three states, OCT0, OCT1, DONE:
  - OCT0 to OCT1 on the complete1 rising edge.
  - OCT1 to DONE on the complete2 rising edge.
  - Any state to OCT0 on frame_start, which also clears x, y, drop_cnt and flushes the FIFO.
  - Edge detection uses a registered copy of complete1/complete2 (reset 0).
- Coordinate counter:
  - Advances only on kp_en in OCT0/OCT1.
  - x increments to W_cur-1, then wraps to 0 and y increments; W_cur = IMG_W in OCT0, IMG_W/2 in OCT1.
  - y wraps from H_cur-1 to 0.
  - kp_en in DONE is ignored; counters hold.
- Capture: kp_en & kp_flag in OCT0/OCT1 pushes {x, y, oct, max, min}, using the counter values before this cycle's increment.
- Octave edge in the same cycle as kp_en: the sample belongs to the old octave and is pushed with the old oct. Counters then reset to 0 for the new octave; the increment is discarded.
- FIFO full at push: the entry is dropped, drop_cnt increments and saturates at 255. A simultaneous pop counts as space: push succeeds when full and m_valid & m_ready.
- Latency: push at cycle N with FIFO empty gives m_valid = 1 at cycle N+1 (registered output head).
- Handshake: while m_valid & !m_ready, all m_* are held stable. m_valid never deasserts without a transfer except on frame_start or reset.
- frame_start during active streaming: FIFO contents are discarded and m_valid = 0 next cycle.
- Reset mid-operation clears everything asynchronously.
- frame_done = (state == DONE) & FIFO empty & !m_valid.

Optional Feature:
- Macro SIFT_KP_CONTRAST_EN.
- Defined: a keypoint is pushed only if (kp_max - kp_min), computed as 9-bit signed, is >= CONTRAST_TH. Rejected keypoints still advance counters and do not touch drop_cnt.
- Undefined: every flagged keypoint is pushed and CONTRAST_TH is unused.

Decomposition:
- Shared package sift_pkg holds:
  - the FSM state encoding (OCT0 = 2'd0, OCT1 = 2'd1, DONE = 2'd2);
  - the keypoint record width constant KP_REC_W = 2*COORD_W+1+16;
  - default IMG_W/IMG_H.
- One sub-module, sift_kp_fifo: synchronous FIFO with registered head, full/empty flags, and simultaneous push/pop when full.

Test Plan:
- Single keypoint: after reset, 5 kp_en with kp_flag only on the 4th (max=40, min=-3), m_ready=1 → exactly one transfer, x=3, y=0, oct=0, max=40, min=-3, at cycle after push.
- Row wrap: IMG_W=8, 9 kp_en with flag on the 9th → x=0, y=1; in OCT1 (after complete1), 5 samples with flag on the 5th → x=0, y=1, oct=1.
- Backpressure/overflow: FIFO_DEPTH=4, m_ready=0, 6 flagged samples → first 4 retained in order, drop_cnt=2, m_* stable; then m_ready=1 drains 4 entries.
- Edge coincidence: complete1 rising in the same cycle as a flagged kp_en at x=2 → entry oct=0, x=2; next flagged sample reports oct=1, x=0, y=0.
- Frame control: complete2 then FIFO drain → frame_done=1; frame_start → frame_done=0, drop_cnt=0, state OCT0; rst low mid-burst → all outputs 0 immediately.
- With SIFT_KP_CONTRAST_EN, CONTRAST_TH=8: max=5, min=-2 (spread 7) rejected; max=5, min=-3 (spread 8) accepted.

Source files
------------

// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT keypoint collector: FSM encoding,
// keypoint record width and default image geometry.
package sift_pkg;

    typedef enum logic [1:0] {
        OCT0 = 2'd0,
        OCT1 = 2'd1,
        DONE = 2'd2
    } kp_state_e;

    localparam int DEF_IMG_W   = 512;
    localparam int DEF_IMG_H   = 512;
    localparam int DEF_COORD_W = 9;

    // Record layout is {x, y, oct, max, min}.
    localparam int KP_REC_W = 2*DEF_COORD_W + 1 + 16;

    function automatic int kp_rec_w(input int coord_w);
        return 2*coord_w + 1 + 16;
    endfunction

endpackage

// File: rtl/sift_kp_collector_if.sv
// Keypoint output stream: valid/ready handshake plus the tagged keypoint fields.
interface sift_kp_collector_if #(
    parameter int COORD_W = 9
);
    logic               m_valid;
    logic               m_ready;
    logic [COORD_W-1:0] m_x;
    logic [COORD_W-1:0] m_y;
    logic               m_oct;
    logic signed [7:0]  m_max;
    logic signed [7:0]  m_min;

    modport master (
        output m_valid, m_x, m_y, m_oct, m_max, m_min,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_x, m_y, m_oct, m_max, m_min,
        output m_ready
    );
endinterface

// File: rtl/sift_kp_fifo.sv
// Synchronous FIFO with a registered head entry; DEPTH counts the head, and a
// pop in the same cycle frees a slot for a push even when full.
module sift_kp_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    mcnt;

    logic pop;
    logic load_head;
    logic mem_has;
    logic accept;
    logic bypass;
    logic mem_wr;
    logic mem_rd;

    assign pop       = head_valid & ready;
    assign load_head = ~head_valid | pop;
    assign mem_has   = (mcnt != '0);
    assign full      = ((mcnt + CW'(head_valid)) == CW'(DEPTH));
    assign empty     = ~mem_has & ~head_valid;
    assign accept    = push & (~full | pop);
    // An empty backing store lets a push land straight in the head register.
    assign bypass    = accept & load_head & ~mem_has;
    assign mem_wr    = accept & ~bypass;
    assign mem_rd    = load_head & mem_has;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            mcnt       <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            mcnt       <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            mcnt <= mcnt + CW'(mem_wr) - CW'(mem_rd);
            if (load_head) begin
                if (mem_has) begin
                    head       <= mem[rd_ptr];
                    head_valid <= 1'b1;
                end else if (bypass) begin
                    head       <= din;
                    head_valid <= 1'b1;
                end else begin
                    head_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sift_kp_collector.sv
// Tags SIFT keypoint strobes with raster position and octave and buffers them
// for a valid/ready consumer. Optional contrast gate: SIFT_KP_CONTRAST_EN.
//
// state | meaning
// OCT0  | collecting full-resolution keypoints
// OCT1  | collecting downsampled-octave keypoints
// DONE  | both octaves complete, samples ignored until frame_start
module sift_kp_collector
    import sift_pkg::*;
#(
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int FIFO_DEPTH  = 16,
    parameter int CONTRAST_TH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      kp_en,
    input  logic                      kp_flag,
    input  logic signed [7:0]         kp_max,
    input  logic signed [7:0]         kp_min,
    input  logic                      complete1,
    input  logic                      complete2,
    input  logic                      frame_start,
    sift_kp_collector_if.master       m,
    output logic [7:0]                drop_cnt,
    output logic                      frame_done
);
    localparam int REC_W = kp_rec_w(COORD_W);

    kp_state_e state;
    kp_state_e state_nxt;

    logic               c1_q;
    logic               c2_q;
    logic               rise1;
    logic               rise2;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w_last;
    logic [COORD_W-1:0] h_last;
    logic               active;
    logic               sample;
    logic               contrast_ok;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [REC_W-1:0]   rec;
    logic [REC_W-1:0]   head;

    assign rise1 = complete1 & ~c1_q;
    assign rise2 = complete2 & ~c2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OCT0;
            c1_q  <= 1'b0;
            c2_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            c1_q  <= complete1;
            c2_q  <= complete2;
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = OCT0;
        end else begin
            case (state)
                OCT0:    if (rise1) state_nxt = OCT1;
                OCT1:    if (rise2) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = OCT0;
            endcase
        end
    end

    assign active = (state == OCT0) | (state == OCT1);
    assign sample = kp_en & active;
    assign w_last = (state == OCT1) ? COORD_W'(IMG_W/2 - 1) : COORD_W'(IMG_W - 1);
    assign h_last = (state == OCT1) ? COORD_W'(IMG_H/2 - 1) : COORD_W'(IMG_H - 1);

    // An octave change restarts the raster; that cycle's increment is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (frame_start || (state_nxt != state)) begin
            x <= '0;
            y <= '0;
        end else if (sample) begin
            if (x == w_last) begin
                x <= '0;
                y <= (y == h_last) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

`ifdef SIFT_KP_CONTRAST_EN
    localparam logic signed [8:0] TH9 = 9'(CONTRAST_TH);
    logic signed [8:0] spread;
    assign spread      = {kp_max[7], kp_max} - {kp_min[7], kp_min};
    assign contrast_ok = (spread >= TH9);
`else
    localparam int unused_contrast_th = CONTRAST_TH;
    assign contrast_ok = 1'b1;
`endif

    assign push = sample & kp_flag & contrast_ok & ~frame_start;
    assign rec  = {x, y, (state == OCT1), kp_max, kp_min};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (frame_start) begin
            drop_cnt <= '0;
        end else if (push && fifo_full && !(m.m_valid && m.m_ready) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    sift_kp_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (frame_start),
        .push       (push),
        .din        (rec),
        .ready      (m.m_ready),
        .head       (head),
        .head_valid (m.m_valid),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign m.m_x   = head[REC_W-1 -: COORD_W];
    assign m.m_y   = head[REC_W-1-COORD_W -: COORD_W];
    assign m.m_oct = head[16];
    assign m.m_max = head[15:8];
    assign m.m_min = head[7:0];

    assign frame_done = (state == DONE) & fifo_empty & ~m.m_valid;

endmodule
